// File: rtl/uart_rx.sv
// UART receive engine: synchronizes the serial line, drives the baud generator's
// start input and samples start/data/stop mid-bit into a valid/ready holding register.
module uart_rx #(
    parameter int DATA_BITS = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    input  logic       baud_tick,
    output logic       baud_start,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       framing_error,
    output logic       overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Data arrives in the shift register MSB; narrow frames are right-justified on completion.
    localparam int         JUSTIFY  = 8 - DATA_BITS;
    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    state_t     state_q, state_d;
    logic       sync1_q, sync1_d;
    logic       rx_s_q, rx_s_d;
    logic       rx_d_q, rx_d_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       framing_error_q, framing_error_d;
    logic       overrun_q, overrun_d;
    logic       line_fall;

    assign line_fall = rx_d_q && !rx_s_q;

    always_comb begin
        sync1_d         = rx;
        rx_s_d          = sync1_q;
        rx_d_d          = rx_s_q;
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        shift_d         = shift_q;
        rx_data_d       = rx_data_q;
        rx_valid_d      = rx_valid_q;
        framing_error_d = 1'b0;
        overrun_d       = 1'b0;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (line_fall) begin
                    state_d = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    if (!rx_s_q) begin
                        state_d   = DATA;
                        bit_cnt_d = 4'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    state_d = IDLE;
                    if (rx_s_q) begin
                        // A consumer taking the old byte this cycle frees the slot for the new one.
                        if (!rx_valid_q || rx_ready) begin
                            rx_data_d  = shift_q >> JUSTIFY;
                            rx_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        framing_error_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            sync1_q         <= 1'b1;
            rx_s_q          <= 1'b1;
            rx_d_q          <= 1'b1;
            bit_cnt_q       <= 4'd0;
            shift_q         <= 8'd0;
            rx_data_q       <= 8'd0;
            rx_valid_q      <= 1'b0;
            framing_error_q <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            sync1_q         <= sync1_d;
            rx_s_q          <= rx_s_d;
            rx_d_q          <= rx_d_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            rx_data_q       <= rx_data_d;
            rx_valid_q      <= rx_valid_d;
            framing_error_q <= framing_error_d;
            overrun_q       <= overrun_d;
        end
    end

    assign baud_start    = (state_q == IDLE);
    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign framing_error = framing_error_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a 5-clock bit period baud generator model;
// covers an 8-bit and a 5-bit instance.
module tb_uart_rx;

    logic       clock;
    logic       reset;
    logic       rx, rx5;
    logic       rx_ready, rx_ready5;
    logic       baud_tick, baud_tick5;
    logic       baud_start, baud_start5;
    logic [7:0] rx_data, rx_data5;
    logic       rx_valid, rx_valid5;
    logic       framing_error, framing_error5;
    logic       overrun, overrun5;

    logic [2:0] cnt_q, cnt5_q;
    int checks = 0;
    int fails  = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int fe0, ov0;

    uart_rx #(.DATA_BITS(8)) u_dut (
        .clock(clock), .reset(reset), .rx(rx), .baud_tick(baud_tick),
        .baud_start(baud_start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .framing_error(framing_error), .overrun(overrun)
    );

    uart_rx #(.DATA_BITS(5)) u_dut5 (
        .clock(clock), .reset(reset), .rx(rx5), .baud_tick(baud_tick5),
        .baud_start(baud_start5), .rx_data(rx_data5), .rx_valid(rx_valid5),
        .rx_ready(rx_ready5), .framing_error(framing_error5), .overrun(overrun5)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Baud generator model: max=4, start holds the counter at max>>1.
    always_ff @(posedge clock) begin
        if (reset || baud_start) cnt_q <= 3'd2;
        else if (cnt_q == 3'd0)  cnt_q <= 3'd4;
        else                     cnt_q <= cnt_q - 3'd1;
    end
    assign baud_tick = (cnt_q == 3'd0);

    always_ff @(posedge clock) begin
        if (reset || baud_start5) cnt5_q <= 3'd2;
        else if (cnt5_q == 3'd0)  cnt5_q <= 3'd4;
        else                      cnt5_q <= cnt5_q - 3'd1;
    end
    assign baud_tick5 = (cnt5_q == 3'd0);

    always @(negedge clock) begin
        if (!reset) begin
            if (framing_error) fe_cnt++;
            if (overrun)       ov_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-18s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive_bit(input bit sel5, input logic b);
        if (sel5) rx5 = b;
        else      rx  = b;
        repeat (5) @(posedge clock);
        #1;
    endtask

    // Start, LSB-first data, stop; returns 1 ns after the last edge of the stop bit.
    task automatic send_frame(input bit sel5, input logic [7:0] data, input int nbits,
                              input logic stop_bit);
        drive_bit(sel5, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(sel5, data[i]);
        drive_bit(sel5, stop_bit);
    endtask

    task automatic clear_hold();
        rx_ready = 1'b1;
        @(posedge clock);
        #1 rx_ready = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Raises rx_ready for exactly the stop-tick cycle of the next frame.
    task automatic ready_at_next_stop();
        int  n = 0;
        bit  seen_idle = 0;
        for (int c = 0; c < 200 && n < 10; c++) begin
            @(negedge clock);
            if (baud_start) seen_idle = 1;
            else if (seen_idle && baud_tick) begin
                n++;
                if (n == 10) begin
                    rx_ready = 1'b1;
                    @(posedge clock);
                    #1 rx_ready = 1'b0;
                end
            end
        end
        check("stop_tick_found", 32'(n), 32'd10);
    endtask

    initial begin
        rx = 1'b1; rx5 = 1'b1; rx_ready = 1'b0; rx_ready5 = 1'b0;
        reset = 1'b1;
        idle_cycles(3);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_fe", 32'(framing_error), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_baud_start", 32'(baud_start), 32'd1);
        reset = 1'b0;
        idle_cycles(5);

        // Single byte 0xA5: valid lands the cycle after the stop tick.
        send_frame(0, 8'hA5, 8, 1'b1);
        check("a5_valid_early", 32'(rx_valid), 32'd0);
        idle_cycles(1);
        check("a5_valid", 32'(rx_valid), 32'd1);
        check("a5_data", 32'(rx_data), 32'hA5);
        idle_cycles(4);
        check("a5_valid_held", 32'(rx_valid), 32'd1);
        check("a5_fe_cnt", 32'(fe_cnt), 32'd0);
        check("a5_ov_cnt", 32'(ov_cnt), 32'd0);
        clear_hold();
        check("a5_valid_clr", 32'(rx_valid), 32'd0);
        check("a5_data_kept", 32'(rx_data), 32'hA5);
        idle_cycles(5);

        // Start-bit glitch of 2 clocks.
        rx = 1'b0;
        idle_cycles(2);
        rx = 1'b1;
        idle_cycles(3);
        check("glitch_in_start", 32'(baud_start), 32'd0);
        idle_cycles(1);
        check("glitch_to_idle", 32'(baud_start), 32'd1);
        idle_cycles(60);
        check("glitch_no_valid", 32'(rx_valid), 32'd0);
        check("glitch_no_fe", 32'(fe_cnt), 32'd0);

        // Framing error on 0x3C, then a clean 0x81.
        send_frame(0, 8'h3C, 8, 1'b0);
        rx = 1'b1;
        idle_cycles(1);
        check("fe_pulse", 32'(framing_error), 32'd1);
        check("fe_no_valid", 32'(rx_valid), 32'd0);
        idle_cycles(1);
        check("fe_pulse_end", 32'(framing_error), 32'd0);
        idle_cycles(5);
        send_frame(0, 8'h81, 8, 1'b1);
        idle_cycles(1);
        check("x81_data", 32'(rx_data), 32'h81);
        check("x81_valid", 32'(rx_valid), 32'd1);
        check("fe_cnt_one", 32'(fe_cnt), 32'd1);
        clear_hold();
        idle_cycles(5);

        // Overrun: back-to-back 0x11, 0x22 with nobody reading.
        ov0 = ov_cnt;
        send_frame(0, 8'h11, 8, 1'b1);
        send_frame(0, 8'h22, 8, 1'b1);
        idle_cycles(1);
        check("ov_pulse", 32'(overrun), 32'd1);
        check("ov_data_kept", 32'(rx_data), 32'h11);
        check("ov_valid", 32'(rx_valid), 32'd1);
        idle_cycles(3);
        check("ov_cnt", 32'(ov_cnt), 32'(ov0 + 1));
        clear_hold();
        idle_cycles(5);

        // Same pair, but the consumer reads on the second completion cycle.
        send_frame(0, 8'h11, 8, 1'b1);
        fork
            send_frame(0, 8'h22, 8, 1'b1);
            ready_at_next_stop();
        join
        check("rdy_data", 32'(rx_data), 32'h22);
        check("rdy_valid", 32'(rx_valid), 32'd1);
        check("rdy_no_ov", 32'(overrun), 32'd0);
        idle_cycles(3);
        check("rdy_ov_cnt", 32'(ov_cnt), 32'(ov0 + 1));
        clear_hold();
        idle_cycles(5);

        // Break: line low for 20 bit periods.
        fe0 = fe_cnt;
        rx = 1'b0;
        idle_cycles(100);
        check("brk_fe_once", 32'(fe_cnt), 32'(fe0 + 1));
        check("brk_idle", 32'(baud_start), 32'd1);
        check("brk_no_valid", 32'(rx_valid), 32'd0);
        rx = 1'b1;
        idle_cycles(20);
        check("brk_no_retrig", 32'(baud_start), 32'd1);
        check("brk_fe_final", 32'(fe_cnt), 32'(fe0 + 1));
        send_frame(0, 8'hC3, 8, 1'b1);
        idle_cycles(1);
        check("brk_next_data", 32'(rx_data), 32'hC3);

        // Reset in the middle of a data phase with the holding register full.
        fork
            send_frame(0, 8'hFF, 8, 1'b1);
            begin
                idle_cycles(20);
                check("mid_frame", 32'(baud_start), 32'd0);
                reset = 1'b1;
                idle_cycles(1);
                reset = 1'b0;
                check("mrst_rx_data", 32'(rx_data), 32'h00);
                check("mrst_rx_valid", 32'(rx_valid), 32'd0);
                check("mrst_fe", 32'(framing_error), 32'd0);
                check("mrst_overrun", 32'(overrun), 32'd0);
                check("mrst_baud_start", 32'(baud_start), 32'd1);
            end
        join
        idle_cycles(10);
        check("mrst_no_frame", 32'(rx_valid), 32'd0);
        send_frame(0, 8'h5A, 8, 1'b1);
        idle_cycles(1);
        check("x5a_data", 32'(rx_data), 32'h5A);
        check("x5a_valid", 32'(rx_valid), 32'd1);

        // Five-bit instance.
        check("db5_rst_valid", 32'(rx_valid5), 32'd0);
        send_frame(1, 8'h15, 5, 1'b1);
        idle_cycles(1);
        check("db5_data", 32'(rx_data5), 32'h15);
        check("db5_valid", 32'(rx_valid5), 32'd1);
        rx_ready5 = 1'b1;
        idle_cycles(1);
        rx_ready5 = 1'b0;
        idle_cycles(5);
        send_frame(1, 8'h1E, 5, 1'b1);
        idle_cycles(1);
        check("db5_data_1e", 32'(rx_data5), 32'h1E);
        check("db5_fe", 32'(framing_error5), 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
